// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seg7_pkg
// Description : Segment codes, digit indices and display-word layout shared
//               by the time-of-day counter and the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [1:0] DIGIT_MIN_U = 2'd0;
    localparam logic [1:0] DIGIT_MIN_T = 2'd1;
    localparam logic [1:0] DIGIT_HR_U  = 2'd2;
    localparam logic [1:0] DIGIT_HR_T  = 2'd3;

    localparam int DW_WIDTH     = 12;
    localparam int DW_VALID_BIT = 11;
    localparam int DW_HOUR_LSB  = 6;
    localparam int DW_HOUR_W    = 5;
    localparam int DW_MIN_LSB   = 0;
    localparam int DW_MIN_W     = 6;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_BUSY = 1'b1
    } conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 6-bit binary to two-digit BCD converter using
//               repeated subtract-10; results held until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    conv_state_t r_state, w_state_n;
    logic [5:0]  r_rem,   w_rem_n;
    logic [3:0]  r_acc,   w_acc_n;
    logic [3:0]  r_tens,  w_tens_n;
    logic [3:0]  r_units, w_units_n;
    logic        r_done,  w_done_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= CONV_IDLE;
            r_rem   <= '0;
            r_acc   <= '0;
            r_tens  <= '0;
            r_units <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_n;
            r_acc   <= w_acc_n;
            r_tens  <= w_tens_n;
            r_units <= w_units_n;
            r_done  <= w_done_n;
        end
    end

    // A new start always restarts, even mid-conversion.
    always_comb begin
        w_state_n = r_state;
        w_rem_n   = r_rem;
        w_acc_n   = r_acc;
        w_tens_n  = r_tens;
        w_units_n = r_units;
        w_done_n  = 1'b0;
        if (start) begin
            w_rem_n   = bin;
            w_acc_n   = '0;
            w_state_n = CONV_BUSY;
        end else if (r_state == CONV_BUSY) begin
            if (r_rem >= 6'd10) begin
                w_rem_n = r_rem - 6'd10;
                w_acc_n = r_acc + 4'd1;
            end else begin
                w_tens_n  = r_acc;
                w_units_n = r_rem[3:0];
                w_done_n  = 1'b1;
                w_state_n = CONV_IDLE;
            end
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed 4-digit HH:MM 7-segment driver with per-frame
//               snapshot, sequential BCD conversion and tear-free updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV_W     = 10,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit LZ_BLANK       = 1'b1
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [DW_WIDTH-1:0] data_show,
    input  logic [2:0]          byte_status,
    output logic [6:0]          segment,
    output logic [3:0]          bytee
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [SCAN_DIV_W-1:0] r_cnt;
    logic [1:0]            r_digit;
    logic [DW_WIDTH-1:0]   r_shadow;
    logic                  r_start;
    logic                  r_hr_rdy, r_min_rdy;
    logic [3:0][6:0]       r_disp;
    logic [3:0][6:0]       w_disp_n;

    logic                  w_cnt_zero, w_snap, w_frame_end;
    logic [DW_HOUR_W-1:0]  w_hour;
    logic [DW_MIN_W-1:0]   w_min;
    logic                  w_valid;
    logic [3:0]            w_hr_t, w_hr_u, w_min_t, w_min_u;
    logic                  w_hr_done, w_min_done;
    logic [1:0]            w_sel;
    logic [6:0]            w_seg;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_snap      = (r_digit == DIGIT_HR_T) && w_cnt_zero;
    assign w_frame_end = (r_digit == DIGIT_HR_T) && (&r_cnt);

    assign w_valid = r_shadow[DW_VALID_BIT];
    assign w_hour  = r_shadow[DW_HOUR_LSB +: DW_HOUR_W];
    assign w_min   = r_shadow[DW_MIN_LSB +: DW_MIN_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_digit <= DIGIT_MIN_U;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_digit <= r_digit + 2'd1;
            end
        end
    end

    // Snapshot one dwell before the frame boundary so conversion completes in time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_start   <= 1'b0;
            r_hr_rdy  <= 1'b0;
            r_min_rdy <= 1'b0;
        end else begin
            r_start <= w_snap;
            if (w_snap) begin
                r_shadow <= data_show;
            end
            if (r_start) begin
                r_hr_rdy  <= 1'b0;
                r_min_rdy <= 1'b0;
            end else begin
                if (w_hr_done)  r_hr_rdy  <= 1'b1;
                if (w_min_done) r_min_rdy <= 1'b1;
            end
        end
    end

    bin2bcd_seq u_hr_bcd (
        .clock (clock),
        .reset (reset),
        .start (r_start),
        .bin   ({1'b0, w_hour}),
        .tens  (w_hr_t),
        .units (w_hr_u),
        .done  (w_hr_done)
    );

    bin2bcd_seq u_min_bcd (
        .clock (clock),
        .reset (reset),
        .start (r_start),
        .bin   (w_min),
        .tens  (w_min_t),
        .units (w_min_u),
        .done  (w_min_done)
    );

    always_comb begin
        w_disp_n = {4{SEG_BLANK}};
        if (w_valid) begin
            if ((w_hour > HOUR_MAX) || (w_min > MIN_MAX)) begin
                w_disp_n = {4{SEG_DASH}};
            end else begin
                w_disp_n[DIGIT_MIN_U] = bcd_to_seg(w_min_u);
                w_disp_n[DIGIT_MIN_T] = bcd_to_seg(w_min_t);
                w_disp_n[DIGIT_HR_U]  = bcd_to_seg(w_hr_u);
                w_disp_n[DIGIT_HR_T]  = (LZ_BLANK && (w_hr_t == 4'd0)) ? SEG_BLANK
                                                                      : bcd_to_seg(w_hr_t);
            end
        end
    end

    // Display regs change only at the frame boundary, so a frame is never mixed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp <= {4{SEG_BLANK}};
        end else if (w_frame_end && r_hr_rdy && r_min_rdy) begin
            r_disp <= w_disp_n;
        end
    end

    assign w_sel = byte_status[2] ? byte_status[1:0] : r_digit;
    assign w_seg = r_disp[w_sel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segment <= SEG_OFF;
            bytee   <= 4'b0000;
        end else begin
            segment <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
            bytee   <= w_cnt_zero ? 4'b0000 : (4'b0001 << w_sel);
        end
    end

endmodule
`default_nettype wire
